// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 8-bit ALU datapath: the serial adder FSM state
// encoding, the adder slice width and the flag-vector bit positions (also used
// by the ALU flag register).
// No ports.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Flag vector layout: {Z, V, C}
    localparam int FLG_C = 0;
    localparam int FLG_V = 1;
    localparam int FLG_Z = 2;
    localparam int FLG_W = 3;

endpackage

// File: rtl/nibble_add.sv
// -----------------------------------------------------------------------------
// nibble_add
// Combinational 4-bit carry-skip adder slice.
// Ports:
//   a, b  in  NIBBLE_W  addend nibbles
//   cin   in  1         carry in
//   s     out NIBBLE_W  sum nibble
//   cout  out 1         carry out (skips the ripple chain when all bits propagate)
// -----------------------------------------------------------------------------
module nibble_add
    import alu_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W:0]   c;
    logic [NIBBLE_W-1:0] p;

    assign p = a ^ b;

    always_comb begin
        // NOTE: every variable driven here gets a value before any branch or
        // loop, so no path leaves it unassigned and no latch is inferred.
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i]   = p[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (p[i] & c[i]);
        end
        // Skip path: when every bit propagates, carry out is simply carry in.
        cout = (&p) ? cin : c[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
// Multi-cycle WIDTH-bit add/subtract unit. Operands are accepted over a
// valid/ready handshake, summed one nibble per clock (LSB nibble first) through
// a single nibble_add slice, and the result with C/V/Z flags is offered over a
// second valid/ready handshake.
// Build option: define ALU_SUB_EN to honour 'sub' (a - b = a + ~b + 1);
// without it 'sub' is ignored and no inversion logic is built.
// Ports:
//   clk, rst            clock (rising) / async active-high reset
//   in_valid, in_ready  operand handshake (in_ready = state is IDLE)
//   a, b, cin, sub      operands, carry in, subtract select
//   out_valid, out_ready result handshake (out_valid = state is DONE)
//   sum, cout, ovf, zero result and flags, held stable while out_valid
// -----------------------------------------------------------------------------
module nibble_serial_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic [FLG_W-1:0]   flags_q;

    logic [WIDTH-1:0]    b_eff;
    logic                c0;
    logic                accept, last;
    logic [31:0]         shamt;
    logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
    logic                nib_c;

    // Operand conditioning at the accept edge.
`ifdef ALU_SUB_EN
    assign b_eff = sub ? ~b : b;
    assign c0    = sub ? 1'b1 : cin;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_eff      = b;
    assign c0         = cin;
`endif

    assign accept = in_valid && (state_q == IDLE);
    assign last   = (idx_q == IDX_W'(NIB - 1));

    // Select the current nibble by shifting it down to bit 0.
    assign shamt = 32'(idx_q) * NIBBLE_W;
    assign nib_a = NIBBLE_W'(a_q >> shamt);
    assign nib_b = NIBBLE_W'(b_q >> shamt);

    nibble_add u_slice (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .s    (nib_s),
        .cout (nib_c)
    );

    // Running result with the current nibble merged in; on the last nibble this
    // is the complete sum, so the flags are derived from it directly.
    assign sum_d = (sum_q & ~(WIDTH'({NIBBLE_W{1'b1}}) << shamt))
                 | (WIDTH'(nib_s) << shamt);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // NOTE: the operand registers carry no reset; they are loaded on every
    // accept and never read before one, so a reset would add nothing.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b_eff;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                carry_q <= c0;
                idx_q   <= '0;
            end else if (state_q == RUN) begin
                sum_q   <= sum_d;
                carry_q <= nib_c;
                if (last) begin
                    flags_q[FLG_C] <= nib_c;
                    flags_q[FLG_V] <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                      (sum_d[WIDTH-1] != a_q[WIDTH-1]);
                    flags_q[FLG_Z] <= (sum_d == '0);
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    // Handshake outputs decode registered state only.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = flags_q[FLG_C];
    assign ovf       = flags_q[FLG_V];
    assign zero      = flags_q[FLG_Z];

endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
// Directed vector table plus hand-written backpressure and reset sequences for
// nibble_serial_adder (WIDTH=8). Expected values follow ALU_SUB_EN.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [7:0] a, b;
    logic       cin, sub;
    logic       out_valid, out_ready;
    logic [7:0] sum;
    logic       cout, ovf, zero;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        logic       zero;
    } vec_t;

    vec_t vecs[$];

    nibble_serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation, scramble the inputs right after accept, measure the
    // latency to out_valid, check the result, then transfer it.
    task automatic run_op(input vec_t v);
        int cycles;
        @(negedge clk);
        check({v.name, ".in_ready"}, 32'(in_ready), 32'd1);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~v.a; b = ~v.b; cin = ~v.cin; sub = ~v.sub;
        @(negedge clk);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        check({v.name, ".latency"}, 32'(cycles), 32'd2);
        check({v.name, ".sum"},  32'(sum),  32'(v.sum));
        check({v.name, ".cout"}, 32'(cout), 32'(v.cout));
        check({v.name, ".ovf"},  32'(ovf),  32'(v.ovf));
        check({v.name, ".zero"}, 32'(zero), 32'(v.zero));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({v.name, ".out_valid_drop"}, 32'(out_valid), 32'd0);
        check({v.name, ".in_ready_back"},  32'(in_ready),  32'd1);
    endtask

    initial begin
        vec_t bp;
        int   cycles;
        int   seen;

        //                name       a      b      cin   sub   sum    c     v     z
        vecs.push_back('{"add",    8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"wrap",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"ovf_ci", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"negneg", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{"nibc",   8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"zeros",  8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
`ifdef ALU_SUB_EN
        vecs.push_back('{"sub",    8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sub_eq", 8'h50, 8'h50, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"sub_ci", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0});
`else
        vecs.push_back('{"sub",    8'h10, 8'h20, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sub_eq", 8'h50, 8'h50, 1'b0, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"sub_ci", 8'h80, 8'h01, 1'b1, 1'b1, 8'h82, 1'b0, 1'b0, 1'b0});
`endif

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.in_ready",  32'(in_ready),  32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.sum",       32'(sum),       32'd0);
        check("rst.flags",     32'({cout, ovf, zero}), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i]);

        // Backpressure: result held 5 cycles while a competing request is ignored.
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 8'hAA; b = 8'h55; cin = 1'b1;
        @(negedge clk);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        check("bp.latency", 32'(cycles), 32'd2);
        for (int k = 0; k < 5; k++) begin
            check("bp.hold_valid", 32'(out_valid), 32'd1);
            check("bp.hold_ready", 32'(in_ready),  32'd0);
            check("bp.hold_sum",   32'(sum),       32'h46);
            check("bp.hold_flags", 32'({cout, ovf, zero}), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp.out_valid_drop", 32'(out_valid), 32'd0);
        check("bp.in_ready_back",  32'(in_ready),  32'd1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("bp.ignored_req", 32'(seen), 32'd0);

        // Reset one cycle after accept: everything clears at once, no result later.
        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst.out_valid", 32'(out_valid), 32'd0);
        check("mid_rst.in_ready",  32'(in_ready),  32'd1);
        check("mid_rst.sum",       32'(sum),       32'd0);
        check("mid_rst.flags",     32'({cout, ovf, zero}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid_rst.no_result", 32'(seen), 32'd0);

        // Recovery after the aborted operation.
        bp = '{"post_rst", 8'h01, 8'h02, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0};
        run_op(bp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit add/subtract unit for the 8-bit ALU datapath. It accepts a full operand pair over a valid/ready handshake, drives the 4-bit carry-skip adder slice one nibble per clock (LSB nibble first), and registers the inter-nibble carry. It assembles the WIDTH-bit result with carry, overflow and zero flags, and presents it downstream over a second valid/ready handshake.

## Interface
- WIDTH, 8, operand/result width; must be a multiple of 4, minimum 4
- clk  in  1  clock, rising-edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add mode only)
- sub  in  1  1 = compute a − b (see Configuration)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB; in subtract mode 1 = no borrow
- ovf  out  1  signed overflow
- zero  out  1  sum == 0

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch a, effective operand b_eff (b, or ~b when subtracting) and carry c0 (cin, or 1 when subtracting);
  - clear the nibble index to 0;
  - go to RUN.
- RUN: in_ready=0, out_valid=0. Each cycle:
  - add nibble k of a and b_eff with the registered carry;
  - write sum nibble k and update the carry register;
  - increment k.
- RUN exit: after nibble NIB-1 (NIB = WIDTH/4), register the flags and go to DONE.
- DONE: out_valid=1, and sum/flags are held stable. On out_ready, go to IDLE.
- Flags:
  - cout = carry out of the last nibble;
  - ovf = (a[MSB]==b_eff[MSB]) && (sum[MSB]!=a[MSB]);
  - zero = all sum bits 0.
- Arithmetic is modulo 2^WIDTH. No saturation.
- Inputs are sampled only at the accept edge. Later changes on a/b/cin/sub have no effect on the operation in flight.
- Reset values (asserted asynchronously, mid-operation included):
  - state = IDLE, in_ready=1, out_valid=0;
  - sum=0, cout=0, ovf=0, zero=0;
  - internal carry and index = 0.
  - An in-flight operation is discarded and never produces an output.

## Timing
- Accept at edge T0. Nibble k is computed in the cycle after edge T0+k.
- out_valid rises after edge T0+NIB. For WIDTH=8, that is 2 cycles after accept.
- The result transfers at the first edge with out_valid&&out_ready. out_valid falls after that edge.
- in_ready rises in the cycle after the transfer. Back-to-back throughput is one operation per NIB+2 cycles.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.
- in_valid asserted while in_ready=0 is ignored. The upstream source must hold its operands until it sees in_ready.

## Configuration
- ALU_SUB_EN defined:
  - sub is honoured;
  - a − b is computed as a + ~b + 1;
  - cin is ignored while sub=1.
- ALU_SUB_EN undefined:
  - sub is ignored, and b_eff = b, carry = cin always;
  - the inversion logic is not compiled.

## Structure
- Shared package alu_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - NIBBLE_W = 4;
  - the flag-vector index constants (FLG_C, FLG_V, FLG_Z), reused by the ALU flag register.
- One sub-module: nibble_add. It is a combinational 4-bit carry-skip slice (a, b, cin → s, cout), instantiated once and time-multiplexed across nibbles.

## Test plan
- Add, no carry: a=0x3C, b=0x0F, cin=0 → sum=0x4B, cout=0, ovf=0, zero=0. out_valid rises exactly 2 cycles after accept.
- Wrap: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0, zero=1.
- Signed overflow plus carry-in: a=0x7F, b=0x00, cin=1 → sum=0x80, cout=0, ovf=1.
- Subtract (ALU_SUB_EN): a=0x10, b=0x20, sub=1 → sum=0xF0, cout=0 (borrow), ovf=0.
  - Repeat with the macro undefined: sum=0x30.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → sum/flags stable, in_ready=0, and a new in_valid is ignored. Release → transfer, then in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst one cycle after accept → out_valid, sum and flags go to 0 immediately and in_ready=1. No result appears after rst is released.
